// File: rtl/msb_rd_sched.sv
// Round-robin read-address scheduler for the multi-stream buffer: arbitrates NREQ consumers
// onto one BRAM read port, tracks per-stream read pointers and fill, returns freed lines.
module msb_rd_sched #(
    parameter int NREQ     = 4,
    parameter int CHANNELS = 2,
    parameter int NSTRMS   = 32,
    parameter int L1_NCL   = 16,
    parameter int WAYS     = 8,
    parameter int CH_W     = $clog2(CHANNELS),
    parameter int G_W      = $clog2(NSTRMS),
    parameter int CL_W     = $clog2(L1_NCL),
    parameter int OF_W     = $clog2(WAYS),
    parameter int GNT_W    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_v,
    output logic [NREQ-1:0]       req_r,
    input  logic [NREQ*G_W-1:0]   req_st,
    input  logic                  wr_commit_v,
    input  logic [G_W-1:0]        wr_commit_st,
    output logic                  rd_free_v,
    output logic [G_W-1:0]        rd_free_st,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [CH_W-1:0]       o_ra_ch,
    output logic [G_W-CH_W-1:0]   o_ra_st,
    output logic [CL_W-1:0]       o_ra_cl,
    output logic [OF_W-1:0]       o_ra_of,
    output logic [GNT_W-1:0]      o_gnt,
    output logic                  err
);

    localparam logic [CL_W:0]   FILL_FULL = (CL_W+1)'(L1_NCL);
    localparam logic [OF_W-1:0] OF_LAST   = OF_W'(WAYS-1);

    logic [CL_W:0]     fill_q  [NSTRMS];
    logic [CL_W:0]     fill_d  [NSTRMS];
    logic [CL_W-1:0]   rd_cl_q [NSTRMS];
    logic [CL_W-1:0]   rd_cl_d [NSTRMS];
    logic [OF_W-1:0]   rd_of_q [NSTRMS];
    logic [OF_W-1:0]   rd_of_d [NSTRMS];
    logic [GNT_W-1:0]  rr_q, rr_d;
    logic              o_v_q, o_v_d;
    logic [G_W-1:0]    o_g_q, o_g_d;
    logic [CL_W-1:0]   o_cl_q, o_cl_d;
    logic [OF_W-1:0]   o_of_q, o_of_d;
    logic [GNT_W-1:0]  o_gnt_q, o_gnt_d;
    logic              free_v_q, free_v_d;
    logic [G_W-1:0]    free_st_q, free_st_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   elig;
    logic              slot_free;
    logic              gnt_v;
    logic [GNT_W-1:0]  gnt_idx;
    logic [GNT_W-1:0]  cand;
    logic [G_W-1:0]    gnt_st;
    logic              last_el;
    logic              commit_cancels;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_v[i] && (fill_q[req_st[i*G_W +: G_W]] != '0);
        end
        slot_free = !o_v_q || o_r;

        // Scan from rr_q upward; the first eligible port wins.
        gnt_v   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = GNT_W'((int'(rr_q) + k) % NREQ);
            if (slot_free && !gnt_v && elig[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end

        gnt_st  = req_st[int'(gnt_idx)*G_W +: G_W];
        last_el = (rd_of_q[gnt_st] == OF_LAST);
        req_r   = gnt_v ? (NREQ'(1) << gnt_idx) : '0;

        fill_d    = fill_q;
        rd_cl_d   = rd_cl_q;
        rd_of_d   = rd_of_q;
        rr_d      = rr_q;
        o_v_d     = o_v_q;
        o_g_d     = o_g_q;
        o_cl_d    = o_cl_q;
        o_of_d    = o_of_q;
        o_gnt_d   = o_gnt_q;
        free_v_d  = 1'b0;
        free_st_d = free_st_q;
        err_d     = err_q;

        if (gnt_v) begin
            o_v_d   = 1'b1;
            o_g_d   = gnt_st;
            o_cl_d  = rd_cl_q[gnt_st];
            o_of_d  = rd_of_q[gnt_st];
            o_gnt_d = gnt_idx;
            rr_d    = GNT_W'((int'(gnt_idx) + 1) % NREQ);
            if (last_el) begin
                rd_of_d[gnt_st] = '0;
                rd_cl_d[gnt_st] = rd_cl_q[gnt_st] + CL_W'(1);
                free_v_d        = 1'b1;
                free_st_d       = gnt_st;
            end else begin
                rd_of_d[gnt_st] = rd_of_q[gnt_st] + OF_W'(1);
            end
        end else if (o_r) begin
            o_v_d = 1'b0;
        end

        // A commit and a free on the same stream in one cycle cancel out.
        commit_cancels = wr_commit_v && free_v_d && (wr_commit_st == gnt_st);
        if (wr_commit_v && !commit_cancels) begin
            if (fill_q[wr_commit_st] == FILL_FULL) begin
                err_d = 1'b1;
            end else begin
                fill_d[wr_commit_st] = fill_q[wr_commit_st] + (CL_W+1)'(1);
            end
        end
        if (free_v_d && !commit_cancels) begin
            fill_d[gnt_st] = fill_q[gnt_st] - (CL_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSTRMS; s++) begin
                fill_q[s]  <= '0;
                rd_cl_q[s] <= '0;
                rd_of_q[s] <= '0;
            end
            rr_q      <= '0;
            o_v_q     <= 1'b0;
            o_g_q     <= '0;
            o_cl_q    <= '0;
            o_of_q    <= '0;
            o_gnt_q   <= '0;
            free_v_q  <= 1'b0;
            free_st_q <= '0;
            err_q     <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            rd_cl_q   <= rd_cl_d;
            rd_of_q   <= rd_of_d;
            rr_q      <= rr_d;
            o_v_q     <= o_v_d;
            o_g_q     <= o_g_d;
            o_cl_q    <= o_cl_d;
            o_of_q    <= o_of_d;
            o_gnt_q   <= o_gnt_d;
            free_v_q  <= free_v_d;
            free_st_q <= free_st_d;
            err_q     <= err_d;
        end
    end

    assign o_v        = o_v_q;
    assign o_ra_ch    = o_g_q[G_W-1 -: CH_W];
    assign o_ra_st    = o_g_q[G_W-CH_W-1:0];
    assign o_ra_cl    = o_cl_q;
    assign o_ra_of    = o_of_q;
    assign o_gnt      = o_gnt_q;
    assign rd_free_v  = free_v_q;
    assign rd_free_st = free_st_q;
    assign err        = err_q;

endmodule

// File: tb/tb_msb_rd_sched.sv
// Bench for msb_rd_sched: directed scenarios plus random traffic against a per-stream
// element-count reference model.
module tb_msb_rd_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_v;
    logic [3:0]  req_r;
    logic [19:0] req_st;
    logic        wr_commit_v;
    logic [4:0]  wr_commit_st;
    logic        rd_free_v;
    logic [4:0]  rd_free_st;
    logic        o_v;
    logic        o_r;
    logic        o_ra_ch;
    logic [3:0]  o_ra_st;
    logic [3:0]  o_ra_cl;
    logic [2:0]  o_ra_of;
    logic [1:0]  o_gnt;
    logic        err;

    always #5 clk = ~clk;

    msb_rd_sched dut (
        .clk(clk), .reset(reset),
        .req_v(req_v), .req_r(req_r), .req_st(req_st),
        .wr_commit_v(wr_commit_v), .wr_commit_st(wr_commit_st),
        .rd_free_v(rd_free_v), .rd_free_st(rd_free_st),
        .o_v(o_v), .o_r(o_r),
        .o_ra_ch(o_ra_ch), .o_ra_st(o_ra_st), .o_ra_cl(o_ra_cl), .o_ra_of(o_ra_of),
        .o_gnt(o_gnt), .err(err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: lines available and elements consumed per stream.
    int m_fill [32];
    int m_pos  [32];
    int m_rr;
    bit m_ov;
    int m_g, m_cl, m_of, m_gn;
    bit m_fv;
    int m_fst;
    bit m_err;

    int gcount, fcount;
    int gq[$];
    int pool[8] = '{0, 1, 3, 5, 16, 17, 30, 31};

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 32; s++) begin
            m_fill[s] = 0;
            m_pos[s]  = 0;
        end
        m_rr = 0; m_ov = 0; m_g = 0; m_cl = 0; m_of = 0; m_gn = 0;
        m_fv = 0; m_fst = 0; m_err = 0;
    endfunction

    // Called at a negedge with inputs applied; returns at the following negedge.
    task automatic step();
        int  w;
        int  g;
        int  p;
        bit  frees;
        #1;
        check("o_v", o_v, m_ov);
        check("o_ra_ch", o_ra_ch, m_g / 16);
        check("o_ra_st", o_ra_st, m_g % 16);
        check("o_ra_cl", o_ra_cl, m_cl);
        check("o_ra_of", o_ra_of, m_of);
        check("o_gnt", o_gnt, m_gn);
        check("rd_free_v", rd_free_v, m_fv);
        check("rd_free_st", rd_free_st, m_fst);
        check("err", err, m_err);
        w = -1;
        if (!m_ov || o_r) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (w < 0 && req_v[p] && m_fill[req_st[p*5 +: 5]] > 0) w = p;
            end
        end
        check("req_r", req_r, (w < 0) ? 0 : (1 << w));
        if (req_r != 0) begin
            gcount++;
            for (int i = 0; i < 4; i++) if (req_r[i]) gq.push_back(i);
        end
        if (rd_free_v) fcount++;
        @(posedge clk);
        g = -1;
        frees = 0;
        if (w >= 0) begin
            g     = int'(req_st[w*5 +: 5]);
            m_ov  = 1;
            m_g   = g;
            m_cl  = (m_pos[g] / 8) % 16;
            m_of  = m_pos[g] % 8;
            m_gn  = w;
            frees = (m_of == 7);
            m_pos[g] = (m_pos[g] + 1) % 128;
            m_rr  = (w + 1) % 4;
        end else if (o_r) begin
            m_ov = 0;
        end
        m_fv = frees;
        if (frees) m_fst = g;
        if (wr_commit_v && !(frees && int'(wr_commit_st) == g)) begin
            if (m_fill[wr_commit_st] == 16) m_err = 1;
            else m_fill[wr_commit_st]++;
        end
        if (frees && !(wr_commit_v && int'(wr_commit_st) == g)) m_fill[g]--;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_v = '0;
        wr_commit_v = 1'b0;
        o_r = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic commit(input int g);
        wr_commit_v  = 1'b1;
        wr_commit_st = 5'(g);
        step();
        wr_commit_v  = 1'b0;
    endtask

    initial begin
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        bit found;
        req_st = '0;
        wr_commit_st = '0;
        do_reset();

        // No committed lines: requests must stall.
        req_v = 4'b0001;
        req_st[4:0] = 5'd3;
        gcount = 0;
        repeat (20) step();
        check("no_fill_grants", gcount, 0);

        // One line on stream 3 yields exactly eight grants and one free.
        req_v = 4'b0000;
        commit(3);
        req_v = 4'b0001;
        gcount = 0; fcount = 0;
        repeat (12) step();
        check("one_line_grants", gcount, 8);
        check("one_line_frees", fcount, 1);

        // Round-robin across four ports, then backpressure.
        do_reset();
        for (int s = 1; s <= 4; s++) commit(s);
        req_st = {5'd4, 5'd3, 5'd2, 5'd1};
        req_v  = 4'b1111;
        gcount = 0;
        gq.delete();
        repeat (6) step();
        check("rr_len", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) check("rr_order", gq[i], exp_order[i]);
        o_r = 1'b0;
        repeat (5) step();
        o_r = 1'b1;
        repeat (30) step();
        check("rr_total_grants", gcount, 32);

        // Stream 17 filled to capacity, overflow commit, commit+free cancellation.
        do_reset();
        for (int i = 0; i < 17; i++) commit(17);
        check("err_after_full", err, 1);
        req_st[4:0] = 5'd17;
        req_v = 4'b0001;
        gcount = 0; fcount = 0;
        for (int k = 0; k < 145; k++) begin
            wr_commit_v  = (k == 7);
            wr_commit_st = 5'd17;
            step();
        end
        wr_commit_v = 1'b0;
        check("full_stream_grants", gcount, 136);
        check("full_stream_frees", fcount, 17);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            req_v = 4'($urandom);
            for (int i = 0; i < 4; i++) req_st[i*5 +: 5] = 5'(pool[$urandom_range(0, 7)]);
            wr_commit_v  = ($urandom_range(0, 2) == 0);
            wr_commit_st = 5'(pool[$urandom_range(0, 7)]);
            o_r = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        commit(5);
        req_st[14:10] = 5'd5;
        req_v = 4'b0100;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (m_ov && m_of == 5) found = 1;
        end
        check("reach_of5", found, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_o_v", o_v, 0);
        check("arst_o_ra_of", o_ra_of, 0);
        check("arst_o_ra_cl", o_ra_cl, 0);
        check("arst_o_gnt", o_gnt, 0);
        check("arst_free_v", rd_free_v, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        req_v = 4'b0000;
        commit(5);
        req_v = 4'b0100;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
